divider_rr_arbiter: RTL and testbench



---
 rtl/divider_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_divider_rr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_rr_arbiter
// Brief    : Round-robin sharing of one sequential divider among NUM_REQ
//            requesters, one operation in flight. Macro DIVARB_DIVZERO_EN
//            answers x/0 locally with all ones instead of using the divider.
// Revision : 1.0 - initial release
// ============================================================================
module divider_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_quotient,
    output logic [DATA_W-1:0]         div_dividend_data,
    output logic [DATA_W-1:0]         div_divisor_data,
    output logic                      div_dividend_valid,
    output logic                      div_divisor_valid,
    input  logic                      div_dividend_ready,
    input  logic                      div_divisor_ready,
    input  logic [DATA_W-1:0]         div_quotient_data,
    input  logic                      div_quotient_valid,
    output logic                      div_quotient_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   c_num_req = (PTR_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_DELIVER  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_dividend;
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero_op;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W:0]       w_sum_wrap;
    logic [PTR_W-1:0]     w_grant;
    logic                 w_grant_vld;
    logic [PTR_W-1:0]     w_owner_inc;
    logic [DATA_W-1:0]    w_sel_dividend;
    logic [DATA_W-1:0]    w_sel_divisor;
    logic                 w_zero_div;
    logic                 w_rsp_acc;

    // Rotate requests so the pointer position lands at bit 0, then take the
    // lowest set bit and add the pointer back modulo NUM_REQ.
    assign w_dbl = {req_valid, req_valid} >> r_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_off       = '0;
        w_grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off       = PTR_W'(k);
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sum_wrap = w_sum - c_num_req;
    assign w_grant    = (w_sum >= c_num_req) ? w_sum_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];
    assign w_owner_inc = (r_owner == c_last) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_sel_dividend = req_dividend[i*DATA_W +: DATA_W];
                w_sel_divisor  = req_divisor[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DIVARB_DIVZERO_EN
    assign w_zero_div = (w_sel_divisor == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    assign w_rsp_acc = rsp_ready[r_owner];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        req_ready          = '0;
        rsp_valid          = '0;
        div_quotient_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by arst so every output reads zero while reset is held.
                if (w_grant_vld && !arst) begin
                    req_ready[w_grant] = 1'b1;
                    w_state_nxt        = w_zero_div ? S_DELIVER : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (div_dividend_ready && div_divisor_ready) begin
                    w_state_nxt = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (div_quotient_valid) begin
                    w_state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: begin
                rsp_valid[r_owner] = 1'b1;
                if (w_rsp_acc) begin
                    div_quotient_ready = !r_zero_op;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
            r_zero_op  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner    <= w_grant;
                        r_dividend <= w_sel_dividend;
                        r_divisor  <= w_sel_divisor;
                        r_zero_op  <= w_zero_div;
                        if (w_zero_div) begin
                            r_result <= '1;
                        end
                    end
                end
                S_WAIT_RES: begin
                    if (div_quotient_valid) begin
                        r_result <= div_quotient_data;
                    end
                end
                S_DELIVER: begin
                    if (w_rsp_acc) begin
                        r_ptr <= w_owner_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_dividend_valid = (r_state == S_ISSUE);
    assign div_divisor_valid  = (r_state == S_ISSUE);
    assign div_dividend_data  = r_dividend;
    assign div_divisor_data   = r_divisor;
    assign rsp_quotient       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_divider_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_rr_arbiter
// Brief    : Scoreboard bench for divider_rr_arbiter with a behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      arst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_dividend;
    logic [NUM_REQ*DATA_W-1:0] req_divisor;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_quotient;
    logic [DATA_W-1:0]         div_dividend_data;
    logic [DATA_W-1:0]         div_divisor_data;
    logic                      div_dividend_valid;
    logic                      div_divisor_valid;
    logic                      div_dividend_ready;
    logic                      div_divisor_ready;
    logic [DATA_W-1:0]         div_quotient_data;
    logic                      div_quotient_valid;
    logic                      div_quotient_ready;

    typedef struct {
        int id;
        int q;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_resp    = 0;
    int   qr_pulses = 0;
    int   n_issue   = 0;
    int   m_lat     = 3;
    int   base_qr;
    int   base_is;

    always #5 clk = ~clk;

    divider_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk               (clk),
        .arst              (arst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_dividend      (req_dividend),
        .req_divisor       (req_divisor),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_quotient      (rsp_quotient),
        .div_dividend_data (div_dividend_data),
        .div_divisor_data  (div_divisor_data),
        .div_dividend_valid(div_dividend_valid),
        .div_divisor_valid (div_divisor_valid),
        .div_dividend_ready(div_dividend_ready),
        .div_divisor_ready (div_divisor_ready),
        .div_quotient_data (div_quotient_data),
        .div_quotient_valid(div_quotient_valid),
        .div_quotient_ready(div_quotient_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = 99;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Behavioural sequential divider with programmable latency.
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;
    int                m_cnt;
    logic              m_busy;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_busy             <= 1'b0;
            m_cnt              <= 0;
            m_a                <= '0;
            m_b                <= '0;
            div_quotient_valid <= 1'b0;
            div_quotient_data  <= '0;
        end else if (!m_busy) begin
            if (div_dividend_valid && div_divisor_valid && div_dividend_ready && div_divisor_ready) begin
                m_busy  <= 1'b1;
                m_cnt   <= m_lat;
                m_a     <= div_dividend_data;
                m_b     <= div_divisor_data;
                n_issue <= n_issue + 1;
            end
        end else if (!div_quotient_valid) begin
            if (m_cnt <= 1) begin
                div_quotient_valid <= 1'b1;
                div_quotient_data  <= (m_b == '0) ? '1 : m_a / m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (div_quotient_ready) begin
            div_quotient_valid <= 1'b0;
            m_busy             <= 1'b0;
        end
    end

    // Mid-cycle monitor: grant order and responses against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!arst) begin
            if (req_ready != '0) begin
                check("req_ready_onehot", $countones(req_ready), 1);
                check("req_ready_without_valid", ((req_ready & ~req_valid) != '0) ? 1 : 0, 0);
                if (gnt_q.size() == 0) check("unexpected_grant", oh_idx(req_ready), 99);
                else check("grant_order", oh_idx(req_ready), gnt_q.pop_front());
            end
            if (rsp_valid != '0) begin
                check("rsp_valid_onehot", $countones(rsp_valid), 1);
                if ((rsp_valid & rsp_ready) != '0) begin
                    n_resp++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_rsp", oh_idx(rsp_valid), 99);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_id", oh_idx(rsp_valid), e.id);
                        check("rsp_quotient", rsp_quotient, e.q);
                    end
                end
            end
            if (div_quotient_ready) begin
                qr_pulses++;
                check("qr_needs_qv", div_quotient_valid, 1);
            end
            if (div_dividend_valid || div_divisor_valid)
                check("divisor_valid_tracks", div_divisor_valid, div_dividend_valid);
        end
    end

    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic expect_op(input int id, input int q);
        exp_t e;
        e.id = id;
        e.q  = q;
        sb_q.push_back(e);
        gnt_q.push_back(id);
    endtask

    task automatic req(input int i, input int a, input int b);
        req_dividend[i*DATA_W +: DATA_W] = DATA_W'(a);
        req_divisor[i*DATA_W +: DATA_W]  = DATA_W'(b);
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_resp(input int k, input int budget, input string tag);
        int target;
        int c;
        target = n_resp + k;
        c = 0;
        while (n_resp < target && c < budget) begin
            step();
            c++;
        end
        check(tag, (n_resp >= target) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        arst      = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        arst               = 1'b1;
        req_valid          = '0;
        req_dividend       = '0;
        req_divisor        = '0;
        rsp_ready          = '1;
        div_dividend_ready = 1'b1;
        div_divisor_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_valid", {div_dividend_valid, div_divisor_valid, div_quotient_ready}, 0);
        check("rst_data", {div_dividend_data, div_divisor_data, rsp_quotient}, 0);
        arst = 1'b0;
        step();
        check("idle_no_grant", req_ready, 0);

        // Single requester 0.
        base_qr = qr_pulses;
        base_is = n_issue;
        expect_op(0, 14);
        req(0, 100, 7);
        wait_resp(1, 50, "t1_done");
        step();
        check("t1_qr_once", qr_pulses - base_qr, 1);
        check("t1_one_issue", n_issue - base_is, 1);

        // All four at once from reset: strict order 0..3.
        do_reset();
        expect_op(0, 20);
        expect_op(1, 10);
        expect_op(2, 3);
        expect_op(3, 15);
        req(0, 200, 10);
        req(1, 50, 5);
        req(2, 9, 3);
        req(3, 255, 16);
        wait_resp(4, 200, "t2_done");

        // Requester 2 stalls its response; a non-owner ready must be ignored.
        rsp_ready = 4'b1011;
        expect_op(2, 11);
        req(2, 77, 7);
        for (int c = 0; c < 50 && !rsp_valid[2]; c++) step();
        check("t3_rsp_seen", rsp_valid, 4'b0100);
        expect_op(0, 15);
        req(0, 60, 4);
        for (int c = 0; c < 10; c++) begin
            step();
            check("t3_hold_valid", rsp_valid, 4'b0100);
            check("t3_hold_q", rsp_quotient, 11);
            check("t3_no_grant", req_ready, 0);
        end
        rsp_ready = '1;
        wait_resp(2, 100, "t3_done");

        // Only the dividend channel ready: issue must not complete.
        base_is = n_issue;
        div_divisor_ready = 1'b0;
        expect_op(1, 9);
        req(1, 81, 9);
        for (int c = 0; c < 20 && !div_dividend_valid; c++) step();
        for (int c = 0; c < 3; c++) begin
            check("t4_valid_held", {div_dividend_valid, div_divisor_valid}, 2'b11);
            check("t4_data_held", {div_dividend_data, div_divisor_data}, {8'd81, 8'd9});
            step();
        end
        check("t4_not_issued", n_issue - base_is, 0);
        div_divisor_ready = 1'b1;
        wait_resp(1, 50, "t4_done");
        check("t4_one_issue", n_issue - base_is, 1);

        // Reset while waiting for the quotient.
        m_lat   = 10;
        base_is = n_issue;
        expect_op(1, 30);
        req(1, 90, 3);
        for (int c = 0; c < 20 && n_issue == base_is; c++) step();
        step();
        req(3, 30, 5);
        step();
        arst = 1'b1;
        #1;
        check("t5_rst_req_ready", req_ready, 0);
        check("t5_rst_rsp_valid", rsp_valid, 0);
        check("t5_rst_valids", {div_dividend_valid, div_divisor_valid, div_quotient_ready}, 0);
        check("t5_rst_data", {div_dividend_data, div_divisor_data, rsp_quotient}, 0);
        sb_q.delete();
        gnt_q.delete();
        m_lat = 3;
        expect_op(0, 5);
        expect_op(3, 6);
        req(0, 40, 8);
        @(posedge clk);
        #1;
        arst = 1'b0;
        wait_resp(2, 100, "t5_done");

        // Zero divisor.
        base_is = n_issue;
        expect_op(1, 255);
        req(1, 42, 0);
        wait_resp(1, 50, "t6_done");
        step();
`ifdef DIVARB_DIVZERO_EN
        check("t6_divider_untouched", n_issue - base_is, 0);
`else
        check("t6_divider_issued", n_issue - base_is, 1);
`endif

        check("sb_drained", sb_q.size(), 0);
        check("grants_drained", gnt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
